ifetch_prefetch: RTL and testbench
==================================

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of PC and memory address.
REQ-002 SHALL have parameter DEPTH, default 4, number of instruction-queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port imem_req  output  1  fetch request valid.
REQ-007 SHALL have port imem_addr  output  ADDR_W  byte address of requested word, low 2 bits zero.
REQ-008 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  read data valid, in order, >=1 cycle after grant.
REQ-010 SHALL have port imem_rdata  input  32  instruction word.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump/jr taken this cycle.
REQ-012 SHALL have port redirect_target  input  ADDR_W  new byte PC.
REQ-013 SHALL have port inst_valid  output  1  queue head valid.
REQ-014 SHALL have port inst_ready  input  1  consumer takes head this cycle.
REQ-015 SHALL have port inst_data  output  32  head instruction.
REQ-016 SHALL have port inst_pc  output  ADDR_W  head instruction byte address.
REQ-017 SHALL have port inst_link  output  ADDR_W  inst_pc+4 (branch base / jal link), modulo 2^ADDR_W.

Function
REQ-018 SHALL implement FSM states FETCH, WAIT, DISCARD; at most one request outstanding.
REQ-019 SHALL assert imem_req in FETCH only when queue count + 0 outstanding < DEPTH, i.e. a free slot is reserved for the response.
REQ-020 SHALL hold imem_req and imem_addr stable until imem_gnt, except on redirect.
REQ-021 SHALL on imem_req&&imem_gnt go FETCH->WAIT and advance fetch_pc by 4, wrapping modulo 2^ADDR_W.
REQ-022 SHALL in WAIT on imem_rvalid push {fetch address, imem_rdata} into the queue and return to FETCH; next request issues no earlier than following cycle.
REQ-023 SHALL ignore imem_rvalid in FETCH (protocol error, no push).
REQ-024 SHALL present queue head combinationally on inst_* outputs; pop on inst_valid&&inst_ready; push and pop in same cycle both take effect.
REQ-025 SHALL on redirect_valid: flush queue (inst_valid low next cycle), set fetch_pc to redirect_target with low 2 bits cleared, ignore same-cycle pop and push.
REQ-026 SHALL on redirect in WAIT without same-cycle imem_rvalid go to DISCARD; with same-cycle imem_rvalid drop the data and go FETCH.
REQ-027 SHALL on redirect in FETCH with same-cycle imem_gnt treat the request as outstanding and go DISCARD; without gnt withdraw request, new address presented next cycle.
REQ-028 SHALL in DISCARD drop the next imem_rvalid and go FETCH; a further redirect in DISCARD only updates fetch_pc.
REQ-029 SHALL give redirect-to-first-request latency of 1 cycle and grant-to-inst_valid latency of rvalid delay + 1 cycle.

Reset
REQ-030 SHALL on reset asynchronously set state FETCH, fetch_pc RESET_PC, queue empty, imem_req 0, inst_valid 0; inst_data/inst_pc/inst_link unspecified while inst_valid 0.
REQ-031 SHALL on reset mid-request abandon it; a stale imem_rvalid in the first cycle after reset deassertion is ignored.
REQ-032 SHALL drive imem_req 0 while reset is asserted; first request in first cycle after release.

Structure
REQ-033 SHALL place FSM state enum and default parameter constants in shared package ifetch_pkg.
REQ-034 SHALL instantiate one sub-module fetch_fifo (synchronous FIFO, width 32+ADDR_W, depth DEPTH, flush input).

Verification
REQ-035 SHALL cover reset release, memory granting immediately with 1-cycle rvalid, inst_ready=1 -> inst_pc 0,4,8,... one per 2 cycles, inst_link = inst_pc+4.
REQ-036 SHALL cover inst_ready=0, DEPTH=4 -> exactly 4 grants, imem_req low thereafter; one pop -> exactly one further request.
REQ-037 SHALL cover redirect to 32'h0000_0103 while in WAIT with rvalid 3 cycles later -> that data dropped, next inst_pc 32'h0000_0100, queue empty meanwhile.
REQ-038 SHALL cover redirect coincident with imem_rvalid and inst_ready -> no push, no pop counted, fetch resumes at target.
REQ-039 SHALL cover fetch_pc at 32'hFFFF_FFFC -> next imem_addr 32'h0000_0000, inst_link 32'h0000_0000.
REQ-040 SHALL cover reset asserted mid-WAIT, rvalid in cycle after release -> ignored, first inst_pc equals RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants and FSM state type for the instruction prefetch unit.
package ifetch_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with head-of-queue read and single-cycle flush.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra pointer bit tells full from empty when the indices match.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: one outstanding fetch at a time, responses queued
// with their PC, redirects flush the queue and discard any in-flight response.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_link
);

    localparam int                ENTRY_W   = 32 + ADDR_W;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    fetch_state_e        state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   req_pc;
    logic                fifo_full;
    logic                fifo_empty;
    logic                grant;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;

    // Requesting only with a free slot reserves room for the response.
    assign imem_req   = !reset && (state == FETCH) && !fifo_full;
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req && imem_gnt;
    assign push       = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid = !fifo_empty;
    assign {inst_pc, inst_data} = head;
    assign inst_link  = inst_pc + ADDR_W'(4);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC & WORD_MASK;
            req_pc   <= '0;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_target & WORD_MASK;
            else if (grant)
                fetch_pc <= fetch_pc + ADDR_W'(4);

            if (grant)
                req_pc <= fetch_pc;

            case (state)
                FETCH: begin
                    if (grant) state <= redirect_valid ? DISCARD : WAIT;
                end
                WAIT: begin
                    if (redirect_valid)   state <= imem_rvalid ? FETCH : DISCARD;
                    else if (imem_rvalid) state <= FETCH;
                end
                DISCARD: begin
                    if (imem_rvalid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fetch_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_data({req_pc, imem_rdata}),
        .pop      (pop),
        .head_data(head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a one-outstanding memory responder.
module tb_ifetch_prefetch;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_link;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] link;
        int          cyc;
    } pop_t;

    pop_t        pops[$];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          grants;
    int          rv_delay;
    int          pend_cnt;
    logic        pend_valid;
    logic [31:0] pend_addr;

    ifetch_prefetch #(
        .ADDR_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_link      (inst_link)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: observe mid-cycle, then drive the responder for the next cycle.
    task automatic tick();
        pop_t p;
        @(negedge clock);
        if (imem_rvalid) pend_valid = 1'b0;
        if (imem_req && imem_gnt) begin
            grants++;
            pend_valid = 1'b1;
            pend_addr  = imem_addr;
            pend_cnt   = rv_delay;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            p.pc = inst_pc; p.data = inst_data; p.link = inst_link; p.cyc = cyc;
            pops.push_back(p);
        end
        @(posedge clock);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (pend_valid && pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b1;
        pend_valid     = 1'b0;
        rv_delay       = 1;
        tick();
        tick();
        imem_rvalid = 1'b0;
        pend_valid  = 1'b0;
        reset = 1'b0;
        #1;
        cyc    = 0;
        grants = 0;
        pops.delete();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; grants = 0;
        reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; inst_ready = 1'b0;
        pend_valid = 1'b0; pend_cnt = 0; pend_addr = '0; rv_delay = 1;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);

        // Streaming: immediate grant, 1-cycle rvalid, consumer always ready.
        do_reset();
        inst_ready = 1'b1;
        check("rel_req", imem_req, 1'b1);
        check("rel_addr", imem_addr, 32'h0);
        repeat (20) tick();
        check("stream_pops", pops.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < pops.size(); i++) begin
            check($sformatf("stream_pc%0d", i), pops[i].pc, 32'(4 * i));
            check($sformatf("stream_data%0d", i), pops[i].data, mem_word(32'(4 * i)));
            check($sformatf("stream_link%0d", i), pops[i].link, 32'(4 * i + 4));
            check($sformatf("stream_cyc%0d", i), pops[i].cyc, 2 + 2 * i);
        end

        // Backpressure: queue fills to DEPTH, one pop admits exactly one more fetch.
        do_reset();
        repeat (20) tick();
        check("full_grants", grants, 4);
        check("full_req", imem_req, 1'b0);
        check("full_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("pop_head", inst_pc, 32'h4);
        repeat (10) tick();
        check("refill_grants", grants, 5);
        check("refill_req", imem_req, 1'b0);

        // Redirect in WAIT, in-flight response arrives 3 cycles after grant.
        do_reset();
        rv_delay = 3;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        for (int c = 2; c < 8; c++) begin
            check($sformatf("wr_empty_c%0d", c), inst_valid, 1'b0);
            if (c < 4) check($sformatf("wr_noreq_c%0d", c), imem_req, 1'b0);
            if (c == 4) check("wr_addr", {imem_req, imem_addr}, {1'b1, 32'h0000_0100});
            tick();
        end
        check("wr_valid", inst_valid, 1'b1);
        check("wr_pc", inst_pc, 32'h0000_0100);
        check("wr_data", inst_data, mem_word(32'h0000_0100));

        // Redirect coincident with rvalid and a ready consumer.
        do_reset();
        repeat (3) tick();
        check("co_head", {inst_valid, inst_pc}, {1'b1, 32'h0});
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0200;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("co_flush", inst_valid, 1'b0);
        check("co_addr", {imem_req, imem_addr}, {1'b1, 32'h0000_0200});
        tick();
        check("co_empty", inst_valid, 1'b0);
        tick();
        check("co_pc", {inst_valid, inst_pc}, {1'b1, 32'h0000_0200});

        // Redirect with same-cycle grant, then address wrap at the top of memory.
        do_reset();
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_discard_req", imem_req, 1'b0);
        tick();
        check("wrap_dropped", inst_valid, 1'b0);
        check("wrap_addr0", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
        tick();
        tick();
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        check("wrap_pc", {inst_valid, inst_pc}, {1'b1, 32'hFFFF_FFFC});
        check("wrap_link", inst_link, 32'h0000_0000);

        // Redirect in FETCH without grant: request retargets next cycle.
        do_reset();
        imem_gnt = 1'b0;
        inst_ready = 1'b1;
        tick();
        check("ng_hold", {imem_req, imem_addr}, {1'b1, 32'h0});
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check("ng_addr", {imem_req, imem_addr}, {1'b1, 32'h0000_0040});
        check("ng_grants", grants, 0);
        imem_gnt = 1'b1;
        tick();
        tick();
        check("ng_pc", {inst_valid, inst_pc}, {1'b1, 32'h0000_0040});
        check("ng_data", inst_data, mem_word(32'h0000_0040));

        // Reset mid-WAIT; stale rvalid lands in the first cycle after release.
        do_reset();
        rv_delay = 3;
        inst_ready = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_req", imem_req, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("stale_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        for (int c = 3; c < 6; c++) begin
            tick();
            check($sformatf("stale_empty_c%0d", c + 1), inst_valid, 1'b0);
        end
        tick();
        check("stale_pc", {inst_valid, inst_pc}, {1'b1, 32'h0});
        check("stale_data", inst_data, mem_word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
